mem_stage_sized: RTL
====================

Name: mem_stage_sized

Overview:
Parametrised successor of the Memory stage. It combines the E->M pipeline register, a word-addressed data RAM and an access sequencer. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. Data RAM reads have a configurable wait-state latency; sub-word stores run as an internal read-merge-write. The block raises StallM to freeze the upstream stages while a multi-cycle access is in progress.

Parameters:
DEPTH, 1024, number of 32-bit words in the data RAM (power of two).
READ_LATENCY, 1, cycles from read issue to data valid (1..7).
AW, $clog2(DEPTH), word-address width derived from DEPTH.

Ports:
CLK  in  1  clock, all state updates on the rising edge
RST_N  in  1  asynchronous active-low reset
RegWriteE  in  1  register write enable from Execute
MemtoRegE  in  1  instruction is a load
MemWriteE  in  1  instruction is a store
ALUOutE  in  32  byte address or ALU result
WriteDataE  in  32  store data
WriteRegE  in  5  destination register
HasDivE  in  1  divide result present
DivHiE  in  32  divide HI
DivLoE  in  32  divide LO
SizeE  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word)
UnsignedE  in  1  zero-extend loads (LBU/LHU)
RegWriteM, MemtoRegM, HasDivM  out  1  registered copies
ALUOutM, DivHiM, DivLoM  out  32  registered copies
WriteRegM  out  5  registered copy
RD  out  32  extended load data, valid when StallM=0
StallM  out  1  hold Fetch/Decode/Execute and this register

Behaviour:
- Reset (RST_N low, asynchronous): every M-side output is 0, StallM=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Pipeline register loads all E inputs on the rising edge when StallM=0. It holds when StallM=1. There is no bubble insertion inside this block.
- Address: word index = ALUOutM[AW+1:2]; lane = ALUOutM[1:0]. Half accesses use lane[1] only; lane[0] is ignored.
- FSM states: IDLE, RD_WAIT, MERGE_WR.
- IDLE, no memory op: 1-cycle pass-through, StallM=0.
- IDLE, word store (MemWriteM & Size=word): writes the RAM at the clock edge, 1 cycle, StallM=0.
- IDLE, load or sub-word store: issues the read, StallM=1, counter=READ_LATENCY-1. Next state is RD_WAIT, or with READ_LATENCY=1 the completion step directly.
- RD_WAIT: counter decrements each cycle. At 0 the data is valid.
  - Load: RD is driven and StallM drops in that same cycle, then IDLE. Total load occupancy is READ_LATENCY+1 cycles.
  - Sub-word store: go to MERGE_WR.
- MERGE_WR: writes {orig with the lane bytes replaced by the low byte/half of WriteDataM}, StallM=0 in that cycle, then IDLE.
- Load extension: byte = lane byte, sign-extended from bit 7 unless UnsignedM. Half = lane half, sign-extended from bit 15 unless UnsignedM. Word = raw.
- MemtoRegM and MemWriteM both set: treated as a store; RD is undefined.
- A store to an address beyond DEPTH words wraps modulo DEPTH.
- Reset mid-access: FSM returns to IDLE. A pending MERGE_WR write is dropped and the RAM is unchanged.
- Back-to-back accesses: the next instruction enters only after StallM=0. Consecutive sub-word stores to the same word must observe the prior merge.

Optional Feature:
MEM_MISALIGN_TRAP_EN.
- When defined: adds output MisalignM (1 bit, reset 0), set combinationally when (half & lane[0]) or (word & lane!=0). On a flagged store the RAM write is suppressed; on a flagged load RD=0. Timing and StallM are unchanged.
- When undefined: no port. Low address bits are forced to alignment (half ignores lane[0], word ignores lane[1:0]).

Decomposition:
- Shared package mem_pkg:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD localparams.
  - FSM state encodings.
  - Lane extract/merge functions.
- One natural sub-module: mem_lane_unit (combinational). Inputs raw word, lane, size, unsigned, store data. Outputs extended load data and merged store word. The RAM stays inline.

Test Plan:
- RAM[0]=0x8081_7F02; LB 0x1 -> RD=0x0000_007F; LB 0x3 -> 0xFFFF_FF80; LBU 0x3 -> 0x0000_0080; with READ_LATENCY=1 each load holds StallM high for exactly 1 cycle.
- RAM[1]=0x1234_8001; LH 0x4 -> 0xFFFF_8001; LHU 0x4 -> 0x0000_8001; LH 0x6 -> 0x0000_1234.
- RAM[2]=0xAABB_CCDD; SB 0x9 data 0x55 -> RAM[2]=0xAABB_55DD; then SH 0xA data 0x7777 -> 0x7777_55DD; StallM pulse lengths equal READ_LATENCY.
- READ_LATENCY=3: LW -> StallM high 3 cycles, upstream ALUOutE changes ignored, RD valid on the cycle StallM falls; SW -> no stall.
- RST_N low during MERGE_WR of SB 0x9 data 0x00 -> RAM[2] unchanged, all outputs 0 immediately, StallM=0.
- With MEM_MISALIGN_TRAP_EN: SW 0x6 -> MisalignM=1, RAM unchanged. Without it: SW 0x6 writes RAM[1].

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: access sizes, sequencer states and
// the byte-lane extract/merge helpers used by loads and sub-word stores.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_MERGE_WR = 2'd2
  } mem_state_t;

  // Size 11 is reserved and behaves as a word access, hence the test on bit 1.
  function automatic logic size_is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] raw,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = raw[{lane, 3'b000} +: 8];
    h = lane[1] ? raw[31:16] : raw[15:0];
    if (size_is_word(size))
      r = raw;
    else if (size == SIZE_HALF)
      r = {{16{h[15] & ~uns}}, h};
    else
      r = {{24{b[7] & ~uns}}, b};
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] raw,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size,
                                             input logic [31:0] wdata);
    logic [31:0] r;
    r = raw;
    if (size_is_word(size))
      r = wdata;
    else if (size == SIZE_HALF) begin
      if (lane[1])
        r[31:16] = wdata[15:0];
      else
        r[15:0] = wdata[15:0];
    end else
      r[{lane, 3'b000} +: 8] = wdata[7:0];
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] lane,
                                      input logic [1:0] size);
    logic m;
    m = 1'b0;
    if (size_is_word(size))
      m = |lane;
    else if (size == SIZE_HALF)
      m = lane[0];
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational byte-lane datapath: extends load data from the RAM word and
// builds the merged word written back by a sub-word store.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  assign load_data = lane_extract(raw, lane, size, uns);
  assign merged    = lane_merge(raw, lane, size, store_data);

endmodule

// File: rtl/mem_stage_sized.sv
// Memory stage: E->M pipeline register, word-addressed data RAM with wait
// states, and a sequencer for loads and read-merge-write sub-word stores.
// Optional macro MEM_MISALIGN_TRAP_EN adds MisalignM and blocks misaligned accesses.
module mem_stage_sized
  import mem_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteRegE,
  input  logic        HasDivE,
  input  logic [31:0] DivHiE,
  input  logic [31:0] DivLoE,
  input  logic [1:0]  SizeE,
  input  logic        UnsignedE,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        HasDivM,
  output logic [31:0] ALUOutM,
  output logic [31:0] DivHiM,
  output logic [31:0] DivLoM,
  output logic [4:0]  WriteRegM,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        MisalignM,
`endif
  output logic [31:0] RD,
  output logic        StallM
);

  localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

  logic        mem_write_m;
  logic [31:0] write_data_m;
  logic [1:0]  size_m;
  logic        unsigned_m;

  mem_state_t  state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   ram [DEPTH];
  logic [31:0]   ram_q;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   load_data;
  logic [31:0]   merged;
  logic          rd_valid;
  logic          stall;
  logic          misalign;
  logic          is_load, is_store, needs_read;

  assign word_idx   = ALUOutM[AW+1:2];
  assign lane       = ALUOutM[1:0];
  // A load with MemWrite also set is executed as a store.
  assign is_load    = MemtoRegM & ~mem_write_m;
  assign is_store   = mem_write_m;
  assign needs_read = is_load | (is_store & ~size_is_word(size_m));

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign  = misaligned(lane, size_m) & (MemtoRegM | mem_write_m);
  assign MisalignM = misalign;
`else
  assign misalign  = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RegWriteM    <= 1'b0;
      MemtoRegM    <= 1'b0;
      HasDivM      <= 1'b0;
      ALUOutM      <= '0;
      DivHiM       <= '0;
      DivLoM       <= '0;
      WriteRegM    <= '0;
      mem_write_m  <= 1'b0;
      write_data_m <= '0;
      size_m       <= '0;
      unsigned_m   <= 1'b0;
    end else if (!stall) begin
      RegWriteM    <= RegWriteE;
      MemtoRegM    <= MemtoRegE;
      HasDivM      <= HasDivE;
      ALUOutM      <= ALUOutE;
      DivHiM       <= DivHiE;
      DivLoM       <= DivLoE;
      WriteRegM    <= WriteRegE;
      mem_write_m  <= MemWriteE;
      write_data_m <= WriteDataE;
      size_m       <= SizeE;
      unsigned_m   <= UnsignedE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Stores leave RD_WAIT one step early so the merge write lands in the
  // cycle the read data becomes valid, keeping their stall at READ_LATENCY.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (needs_read) begin
          cnt_next = LAT_M1;
          if (is_store && READ_LATENCY == 1)
            state_next = ST_MERGE_WR;
          else
            state_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_reg != 3'd0)
          cnt_next = cnt_reg - 3'd1;
        if (is_store) begin
          if (cnt_reg == 3'd1)
            state_next = ST_MERGE_WR;
        end else if (cnt_reg == 3'd0) begin
          state_next = ST_IDLE;
        end
      end
      ST_MERGE_WR: state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = write_data_m;
    rd_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        stall  = needs_read;
        ram_we = is_store & size_is_word(size_m) & ~misalign;
      end
      ST_RD_WAIT: begin
        rd_valid = is_load && (cnt_reg == 3'd0);
        stall    = ~rd_valid;
      end
      ST_MERGE_WR: begin
        ram_we    = ~misalign;
        ram_wdata = merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (ram_we)
      ram[word_idx] <= ram_wdata;
    ram_q <= ram[word_idx];
  end

  mem_lane_unit u_lane (
    .raw        (ram_q),
    .lane       (lane),
    .size       (size_m),
    .uns        (unsigned_m),
    .store_data (write_data_m),
    .load_data  (load_data),
    .merged     (merged)
  );

  assign StallM = stall;
  assign RD     = (rd_valid && !misalign) ? load_data : 32'h0;

endmodule
